// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the divider and its mantissa datapath.
// Format constants, divider FSM state type and a field-packing helper.
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIVIDE,
        NORM
    } div_state_t;

    function automatic logic [15:0] fp16_pack(
        input logic       s,
        input logic [4:0] e,
        input logic [9:0] m
    );
        return {s, e, m};
    endfunction

endpackage

// File: rtl/mant_restoring_div.sv
// 11-bit by 11-bit restoring mantissa divider, one quotient bit per step.
// Thirteen steps produce floor(ma * 4096 / mb) in the quotient register.
module mant_restoring_div
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [10:0] ma,
    input  logic [10:0] mb,
    output logic [11:0] quot,
    output logic        finished
);

    logic [11:0] rem;
    logic [10:0] dvs;
    logic [12:0] q;
    logic [3:0]  cnt;

    logic        qbit;
    logic [11:0] diff;
    logic [11:0] kept;
    logic [11:0] rem_nx;

    // Trial subtraction; the kept value is always below the divisor,
    // so its top bit is free and the shift never loses information.
    always_comb begin
        qbit   = (rem >= {1'b0, dvs});
        diff   = rem - {1'b0, dvs};
        kept   = qbit ? diff : rem;
        rem_nx = {kept[10:0], 1'b0};
    end

    // Remainder, divisor, quotient shift register and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= {1'b0, ma};
            dvs <= mb;
            q   <= '0;
            cnt <= '0;
        end else if (step) begin
            rem <= rem_nx;
            q   <= {q[11:0], qbit};
            cnt <= cnt + 4'd1;
        end
    end

    // The quotient LSB never reaches the 10-bit mantissa.
    assign quot     = q[12:1];
    // High while the thirteenth quotient bit is being produced.
    assign finished = (cnt == 4'd12);

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider (out = a / b), fixed 15-cycle latency.
// Optional macro FP16_DIV_SPECIAL_EN adds zero/inf/NaN and range handling.
module fp16_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

`ifdef FP16_DIV_SPECIAL_EN
    localparam int EW = 7;
`else
    // Without range checks only the wrapped 5-bit field is ever used.
    localparam int EW = 5;
`endif

    div_state_t state;
    div_state_t state_nx;

    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        sign_r;
    logic signed [EW-1:0] e_r;

    logic accept;
    logic load;
    logic step;
    logic norm;

    logic [11:0] quot;
    logic        finished;

    logic signed [EW-1:0] e_fin;
    logic [9:0]  man;
    logic [15:0] res;

    assign accept = (state == IDLE) && start && !busy;

    mant_restoring_div u_mdiv (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .ma       ({1'b1, a_r[9:0]}),
        .mb       ({1'b1, b_r[9:0]}),
        .quot     (quot),
        .finished (finished)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state datapath strobes.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        norm     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                state_nx = DIVIDE;
            end
            DIVIDE: begin
                step = 1'b1;
                if (finished) state_nx = NORM;
            end
            NORM: begin
                norm     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Normalize the quotient and resolve special operands.
    always_comb begin
        e_fin = quot[11] ? e_r : e_r - EW'(1);
        man   = quot[11] ? quot[10:1] : quot[9:0];
        res   = fp16_pack(sign_r, e_fin[4:0], man);
`ifdef FP16_DIV_SPECIAL_EN
        begin
            logic a_zero, a_inf, a_nan;
            logic b_zero, b_inf, b_nan;
            a_zero = (a_r[14:10] == 5'd0);
            b_zero = (b_r[14:10] == 5'd0);
            a_inf  = (a_r[14:10] == FP16_EXP_MAX) && (a_r[9:0] == 10'd0);
            b_inf  = (b_r[14:10] == FP16_EXP_MAX) && (b_r[9:0] == 10'd0);
            a_nan  = (a_r[14:10] == FP16_EXP_MAX) && (a_r[9:0] != 10'd0);
            b_nan  = (b_r[14:10] == FP16_EXP_MAX) && (b_r[9:0] != 10'd0);
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
                res = FP16_QNAN;
            else if (a_inf || b_zero)
                res = fp16_pack(sign_r, FP16_EXP_MAX, 10'd0);
            else if (a_zero || b_inf)
                res = fp16_pack(sign_r, 5'd0, 10'd0);
            else if (e_fin > 7'sd30)
                res = fp16_pack(sign_r, FP16_EXP_MAX, 10'd0);
            else if (e_fin < 7'sd1)
                res = fp16_pack(sign_r, 5'd0, 10'd0);
        end
`endif
    end

    // Operand capture, sign/exponent path and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            e_r    <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= norm;
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (load) begin
                sign_r <= a_r[15] ^ b_r[15];
                e_r    <= EW'(a_r[14:10]) - EW'(b_r[14:10])
                        + EW'(FP16_BIAS);
            end
            if (norm) begin
                out <= res;
            end
        end
    end

endmodule

// File: tb/tb_fp16_divider.sv
// Directed self-checking bench for fp16_divider.
// Define FP16_DIV_SPECIAL_EN to also exercise the special-case vectors.
module tb_fp16_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    fp16_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one operation; poke>0 pulses a stray start after edge T0+poke.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input int poke, output logic [15:0] res,
                          output int lat, output logic busy_ok,
                          output logic idle_ok);
        @(posedge clk);
        #1;
        idle_ok = !busy && !done;
        a = ta;
        b = tb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hFFFF;
        b = 16'h1234;
        busy_ok = busy;
        lat = 99;
        res = 16'hxxxx;
        for (int k = 1; k <= 40; k++) begin
            if (poke > 0 && k == poke) begin
                start = 1'b1;
                a = 16'h4000;
                b = 16'h3C00;
            end
            @(posedge clk);
            #1;
            if (poke > 0 && k == poke) start = 1'b0;
            busy_ok = busy_ok && busy;
            if (done) begin
                lat = k;
                res = out;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] res;
        int          lat;
        logic        bok;
        logic        iok;
        int          dseen;

        vecs.push_back('{16'h4600, 16'h4000, 16'h4200});
        vecs.push_back('{16'h3C00, 16'h4200, 16'h3555});
        vecs.push_back('{16'hC600, 16'h4000, 16'hC200});
        vecs.push_back('{16'h4000, 16'h4000, 16'h3C00});
        vecs.push_back('{16'h4000, 16'h3C00, 16'h4000});
        vecs.push_back('{16'h3C00, 16'hC000, 16'hB800});
`ifdef FP16_DIV_SPECIAL_EN
        vecs.push_back('{16'h3C00, 16'h0000, 16'h7C00});
        vecs.push_back('{16'h0000, 16'h0000, 16'h7E00});
        vecs.push_back('{16'h7BFF, 16'h0400, 16'h7C00});
        vecs.push_back('{16'h0400, 16'h7BFF, 16'h0000});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, res, lat, bok, iok);
            chk($sformatf("v%0d_out", i), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd15);
            chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
            chk($sformatf("v%0d_idle", i), 32'(iok), 32'd1);
        end

        run_op(16'hC600, 16'h4000, 0, res, lat, bok, iok);
        chk("b2b_first", 32'(res), 32'hC200);
        run_op(16'h4000, 16'h4000, 0, res, lat, bok, iok);
        chk("b2b_second", 32'(res), 32'h3C00);
        chk("b2b_lat", 32'(lat), 32'd15);
        chk("b2b_idle", 32'(iok), 32'd1);

        run_op(16'h4600, 16'h4000, 5, res, lat, bok, iok);
        chk("poke_out", 32'(res), 32'h4200);
        chk("poke_lat", 32'(lat), 32'd15);
        @(posedge clk);
        #1;
        chk("poke_busy_drop", 32'(busy), 32'h0);
        dseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dseen++;
        end
        chk("poke_no_queue", 32'(dseen), 32'd0);

        @(posedge clk);
        #1;
        a = 16'h3C00;
        b = 16'h4200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out", 32'(out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) dseen++;
        end
        chk("abort_no_done", 32'(dseen), 32'd0);
        run_op(16'h3C00, 16'h4200, 0, res, lat, bok, iok);
        chk("abort_recover_out", 32'(res), 32'h3555);
        chk("abort_recover_lat", 32'(lat), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
